seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture_if.sv | 25 ++
 rtl/seg7_capture.sv | 184 ++++++++++++++++++
 tb/tb_seg7_capture.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// seg7_capture_if -- bus bundle for the seven-segment capture block.
//   iSeg    [6:0]  segment bus, active-low, bit0=a .. bit6=g
//   iAn     [7:0]  digit anode selects, active-low
//   iClear         synchronous clear of captured state
//   oDigits [31:0] captured codes, position n at [4n+3:4n]
//   oValid  [7:0]  per-position valid flags
//   oUpdate        one-cycle pulse on every position write
//   oErr           sticky undecodable-pattern flag
//   oErrCnt [7:0]  undecodable-pattern count (0 unless the counter is built)
// Modports: slave = the capture block, master = whoever drives the display bus.
interface seg7_capture_if;
  logic [6:0]  iSeg;
  logic [7:0]  iAn;
  logic        iClear;
  logic [31:0] oDigits;
  logic [7:0]  oValid;
  logic        oUpdate;
  logic        oErr;
  logic [7:0]  oErrCnt;

  modport slave  (input  iSeg, iAn, iClear,
                  output oDigits, oValid, oUpdate, oErr, oErrCnt);
  modport master (output iSeg, iAn, iClear,
                  input  oDigits, oValid, oUpdate, oErr, oErrCnt);
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture -- snoops a multiplexed 7-segment display bus and recovers the
// digit shown at each of 8 positions once the {anode, segment} pair has been
// stable for STABLE_CYCLES consecutive samples.
// Ports:
//   iClk    clock, rising edge
//   iRst_n  asynchronous active-low reset
//   bus     seg7_capture_if.slave (segments/anodes in, captured digits out)
// Optional feature: define SEG7_CAPTURE_ERRCNT_EN to build the saturating
// undecodable-pattern counter on oErrCnt; otherwise oErrCnt is tied to 0.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic          iClk,
  input  logic          iRst_n,
  seg7_capture_if.slave bus
);

  localparam logic [7:0] STB = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Entry registers plus a one-sample-old copy used for change detection.
  logic [6:0] seg_q, seg_prev_q;
  logic [7:0] an_q, an_prev_q;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cap;

  logic [7:0][3:0] digits_q, digits_d;
  logic [7:0]      valid_q, valid_d;
  logic            upd_q, upd_d;
  logic            err_q, err_d;

  logic       sel, same, dec_ok;
  logic [3:0] dec_code;
  logic [2:0] pos;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      seg_q      <= '1;
      an_q       <= '1;
      seg_prev_q <= '1;
      an_prev_q  <= '1;
    end else begin
      seg_q      <= bus.iSeg;
      an_q       <= bus.iAn;
      seg_prev_q <= seg_q;
      an_prev_q  <= an_q;
    end
  end

  // Segment pattern (g..a) to hex code; blank shows as F.
  always_comb begin
    dec_ok   = 1'b1;
    dec_code = 4'h0;
    case (seg_q)
      7'b1000000: dec_code = 4'h0;
      7'b1111001: dec_code = 4'h1;
      7'b0100100: dec_code = 4'h2;
      7'b0110000: dec_code = 4'h3;
      7'b0011001: dec_code = 4'h4;
      7'b0010010: dec_code = 4'h5;
      7'b0000010: dec_code = 4'h6;
      7'b1111000: dec_code = 4'h7;
      7'b0000000: dec_code = 4'h8;
      7'b0010000: dec_code = 4'h9;
      7'b1110111: dec_code = 4'hA;
      7'b0111111: dec_code = 4'hB;
      7'b1111110: dec_code = 4'hC;
      7'b1111111: dec_code = 4'hF;
      default:    dec_ok   = 1'b0;
    endcase
  end

  always_comb begin
    pos = 3'd0;
    for (int i = 0; i < 8; i++)
      if (!an_q[i]) pos = i[2:0];
  end

  assign sel  = $onehot(~an_q);
  assign same = (an_q == an_prev_q) && (seg_q == seg_prev_q);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (bus.iClear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE, HOLD: begin
        if (!same) begin
          state_d = sel ? SETTLE : IDLE;
          cnt_d   = sel ? 8'd1 : 8'd0;
        end else if (state_q == SETTLE) begin
          // Counting stops at STB: capture fires on the increment that reaches it.
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == STB - 8'd1) begin
            state_d = HOLD;
            cap     = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    upd_d    = 1'b0;
    err_d    = err_q;
    if (cap) begin
      if (dec_ok) begin
        digits_d[pos] = dec_code;
        valid_d[pos]  = 1'b1;
        upd_d         = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      digits_q <= '0;
      valid_q  <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (bus.iClear) begin
      digits_q <= '0;
      valid_q  <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0] errcnt_q;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)
      errcnt_q <= '0;
    else if (bus.iClear)
      errcnt_q <= '0;
    else if (cap && !dec_ok && errcnt_q != 8'hFF)
      errcnt_q <= errcnt_q + 8'd1;
  end
  assign bus.oErrCnt = errcnt_q;
`else
  assign bus.oErrCnt = 8'h00;
`endif

  assign bus.oDigits = digits_q;
  assign bus.oValid  = valid_q;
  assign bus.oUpdate = upd_q;
  assign bus.oErr    = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture -- directed table plus hand sequences for seg7_capture
// (STABLE_CYCLES=4).
module tb_seg7_capture;

`ifdef SEG7_CAPTURE_ERRCNT_EN
  localparam bit ECNT = 1'b1;
`else
  localparam bit ECNT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_if bus();

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic [31:0] dig;
    logic [7:0]  vld;
    logic        err;
    int          ecnt;
    int          pulses;
  } vec_t;

  vec_t tbl[18];

  // Apply a pair for n cycles, counting update pulses sampled on negedge.
  task automatic dwell(input logic [7:0] an, input logic [6:0] seg, input int n, output int p);
    bus.iAn  = an;
    bus.iSeg = seg;
    p = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.oUpdate) p++;
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] dig, input logic [7:0] vld,
                         input logic err, input int ecnt);
    chk({tag, ".digits"}, bus.oDigits, dig);
    chk({tag, ".valid"},  {24'h0, bus.oValid}, {24'h0, vld});
    chk({tag, ".err"},    {31'h0, bus.oErr}, {31'h0, err});
    chk({tag, ".errcnt"}, {24'h0, bus.oErrCnt}, ECNT ? 32'(ecnt) : 32'h0);
  endtask

  logic [6:0] codes[8];

  initial begin
    int p;
    codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    tbl[0]  = '{8'hFE, 7'b1000000,  6, 32'h00000000, 8'h01, 1'b0, 0, 1};
    tbl[1]  = '{8'hFD, 7'b1111001,  6, 32'h00000010, 8'h03, 1'b0, 0, 1};
    tbl[2]  = '{8'hFB, 7'b0100100,  6, 32'h00000210, 8'h07, 1'b0, 0, 1};
    tbl[3]  = '{8'hF7, 7'b0110000,  6, 32'h00003210, 8'h0F, 1'b0, 0, 1};
    tbl[4]  = '{8'hEF, 7'b0011001,  6, 32'h00043210, 8'h1F, 1'b0, 0, 1};
    tbl[5]  = '{8'hDF, 7'b0010010,  6, 32'h00543210, 8'h3F, 1'b0, 0, 1};
    tbl[6]  = '{8'hBF, 7'b0000010,  6, 32'h06543210, 8'h7F, 1'b0, 0, 1};
    tbl[7]  = '{8'h7F, 7'b1111000,  6, 32'h76543210, 8'hFF, 1'b0, 0, 1};
    tbl[8]  = '{8'hFE, 7'b0000000,  6, 32'h76543218, 8'hFF, 1'b0, 0, 1};
    tbl[9]  = '{8'hFD, 7'b0010000,  6, 32'h76543298, 8'hFF, 1'b0, 0, 1};
    tbl[10] = '{8'hFB, 7'b1110111,  6, 32'h76543A98, 8'hFF, 1'b0, 0, 1};
    tbl[11] = '{8'hF7, 7'b0111111,  6, 32'h7654BA98, 8'hFF, 1'b0, 0, 1};
    tbl[12] = '{8'hEF, 7'b1111110,  6, 32'h765CBA98, 8'hFF, 1'b0, 0, 1};
    tbl[13] = '{8'hDF, 7'b1111111,  6, 32'h76FCBA98, 8'hFF, 1'b0, 0, 1};
    tbl[14] = '{8'hFB, 7'b0101010,  6, 32'h76FCBA98, 8'hFF, 1'b1, 1, 0};
    tbl[15] = '{8'hF0, 7'b1000000, 10, 32'h76FCBA98, 8'hFF, 1'b1, 1, 0};
    tbl[16] = '{8'h7F, 7'b0000001,  6, 32'h76FCBA98, 8'hFF, 1'b1, 2, 0};
    tbl[17] = '{8'hBF, 7'b1111001, 12, 32'h71FCBA98, 8'hFF, 1'b1, 2, 1};

    bus.iAn = 8'hFF; bus.iSeg = 7'h7F; bus.iClear = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 32'h0, 8'h00, 1'b0, 0);
    chk("reset.update", {31'h0, bus.oUpdate}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      dwell(tbl[i].an, tbl[i].seg, tbl[i].hold, p);
      chk($sformatf("vec%0d.pulses", i), p, tbl[i].pulses);
      chk_all($sformatf("vec%0d", i), tbl[i].dig, tbl[i].vld, tbl[i].err, tbl[i].ecnt);
    end

    // Clear, then exact capture latency: one pulse visible after edge 5 only.
    bus.iAn = 8'hFF; bus.iClear = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.iClear = 1'b0;
    chk_all("clear", 32'h0, 8'h00, 1'b0, 0);
    bus.iAn = 8'hFE; bus.iSeg = 7'b0110000;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("lat.edge%0d", e), {31'h0, bus.oUpdate}, (e == 5) ? 32'h1 : 32'h0);
    end
    chk_all("lat", 32'h3, 8'h01, 1'b0, 0);

    // Pair changes every 3 cycles: dwell never completes.
    begin
      int tot = 0;
      for (int k = 0; k < 8; k++) begin
        dwell(~(8'h01 << ((k + 1) % 8)), codes[k], 3, p);
        tot += p;
      end
      chk("fast.pulses", tot, 0);
      chk_all("fast", 32'h3, 8'h01, 1'b0, 0);
    end

    // Reset with the counter at 3, then a full new dwell is required.
    bus.iAn = 8'hFD; bus.iSeg = 7'b1111001;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 32'h0, 8'h00, 1'b0, 0);
    chk("midrst.update", {31'h0, bus.oUpdate}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("postrst.edge%0d", e), {31'h0, bus.oUpdate}, (e == 5) ? 32'h1 : 32'h0);
    end
    chk_all("postrst", 32'h10, 8'h02, 1'b0, 0);

    // Set the error flag, then clear on the capture edge of a new dwell.
    dwell(8'hFB, 7'b0101010, 6, p);
    chk_all("err2", 32'h10, 8'h02, 1'b1, 1);
    bus.iAn = 8'hFB; bus.iSeg = 7'b0100100;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.iClear = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.iClear = 1'b0;
    chk("clrcap.update", {31'h0, bus.oUpdate}, 32'h0);
    chk_all("clrcap", 32'h0, 8'h00, 1'b0, 0);
    bus.iAn = 8'hFF;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
